// File: rtl/ooca_pkg.sv
// Shared types for the fetch stage: bus widths, fetch FSM states and the
// prefetch FIFO entry layout.
package ooca_pkg;

    localparam int WORD_W = 16;
    localparam int ADDR_W = 16;

    localparam logic [WORD_W-1:0] NOP = 16'h0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT
    } fetch_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [WORD_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small prefetch FIFO between the ROM capture point and decode.
// Flush clears occupancy only; stale storage is never visible because count gates the head.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [W-1:0]               data_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic [W-1:0]               head_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_q] <= data_i;
    end

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + AW'(1);
            if (pop_i)  rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
        end
    end

    assign count_o = cnt_q;
    assign head_o  = mem_q[rd_q];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: walks the PC, strobes the ROM, captures after ROM_LAT
// cycles and feeds decode through a prefetch FIFO with branch redirect.
module fetch_unit
    import ooca_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000,
    parameter int                ROM_LAT  = 1,
    parameter int                DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [WORD_W-1:0] rom_wdata,
    output logic              rom_rd,
    output logic              rom_wr,
    output logic              rom_cs,
    input  logic [WORD_W-1:0] rom_rdata,
    output logic              instr_valid,
    output logic [WORD_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              instr_ready
);

    localparam int             CW      = $clog2(DEPTH) + 1;
    localparam logic [2:0]     LAT_M1  = 3'(ROM_LAT - 1);
    localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);

    fetch_state_e      state_q;
    logic [ADDR_W-1:0] pc_q, rom_addr_q;
    logic [2:0]        cnt_q;
    logic              rom_cs_q, rom_rd_q;

    logic [CW-1:0]     fifo_cnt, post_cnt;
    fetch_entry_t      head, push_data;
    logic              push, pop, capture, room_idle, room_after;

    assign instr_valid = (fifo_cnt != '0);
    assign pop         = instr_valid && instr_ready;
    assign capture     = (state_q == ST_WAIT) && (cnt_q == 3'd0);
    // A redirect discards the word landing this cycle.
    assign push        = capture && !redirect_valid;
    assign push_data   = '{pc: pc_q, instr: rom_rdata};
    assign post_cnt    = fifo_cnt + CW'(1) - CW'(pop);
    assign room_idle   = fifo_cnt < DEPTH_C;
    assign room_after  = post_cnt < DEPTH_C;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(fetch_entry_t))
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .data_i  (push_data),
        .pop_i   (pop),
        .flush_i (redirect_valid),
        .count_o (fifo_cnt),
        .head_o  (head)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            cnt_q      <= '0;
            rom_cs_q   <= 1'b0;
            rom_rd_q   <= 1'b0;
            rom_addr_q <= '0;
        end else begin
            rom_cs_q <= 1'b0;
            rom_rd_q <= 1'b0;
            if (redirect_valid) begin
                state_q <= ST_IDLE;
                pc_q    <= redirect_pc;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: if (en && room_idle) begin
                        state_q    <= ST_REQ;
                        rom_cs_q   <= 1'b1;
                        rom_rd_q   <= 1'b1;
                        rom_addr_q <= pc_q;
                    end
                    ST_REQ: begin
                        state_q <= ST_WAIT;
                        cnt_q   <= LAT_M1;
                    end
                    ST_WAIT: if (cnt_q != 3'd0) begin
                        cnt_q <= cnt_q - 3'd1;
                    end else begin
                        pc_q <= pc_q + 16'd1;
                        // Back-to-back issue needs room after this cycle's push/pop.
                        if (en && room_after) begin
                            state_q    <= ST_REQ;
                            rom_cs_q   <= 1'b1;
                            rom_rd_q   <= 1'b1;
                            rom_addr_q <= pc_q + 16'd1;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign rom_cs    = rom_cs_q;
    assign rom_rd    = rom_rd_q;
    assign rom_addr  = rom_addr_q;
    assign rom_wr    = 1'b0;
    assign rom_wdata = '0;
    assign instr     = instr_valid ? head.instr : '0;
    assign instr_pc  = instr_valid ? head.pc    : '0;

endmodule
